// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states and requester IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating grant-hold counter with a sticky timeout flag.
module arb_hold_timer #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic err_o
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          expire;

  assign expire = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Burst-granular arbiter sharing banked main memory between I-cache and D-cache,
// with a drain phase so returning bank data always reaches the issuing cache.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BANKS    = 4,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_wr,
  input  logic              i_rd,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_data_out,
  output logic [BANKS-1:0]  i_busy,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  input  logic              d_wr,
  input  logic              d_rd,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_data_out,
  output logic [BANKS-1:0]  d_busy,
  output logic              d_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic [BANKS-1:0]  m_busy,
  input  logic              m_err,
  output logic              arb_err
);

  import mem_arbiter_pkg::*;

  arb_state_e state_q, state_d;
  req_id_e    prio_q, prio_d;
  req_id_e    owner_q, owner_d;
  logic       hold_clr, granted, routed, proto_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wr, sel_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= REQ_D;
      owner_q <= REQ_I;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // owner_q is latched at grant and kept through DRAIN for return routing.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    hold_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          owner_d = prio_q;
          prio_d  = (prio_q == REQ_I) ? REQ_D : REQ_I;
        end else if (i_req) begin
          owner_d = REQ_I;
        end else if (d_req) begin
          owner_d = REQ_D;
        end
        if (i_req || d_req) begin
          state_d  = (owner_d == REQ_I) ? ST_GRANT_I : ST_GRANT_D;
          hold_clr = 1'b1;
        end
      end
      ST_GRANT_I: if (!i_req) state_d = ST_DRAIN;
      ST_GRANT_D: if (!d_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (m_busy == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign granted = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
  assign routed  = granted || (state_q == ST_DRAIN);

  arb_hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (hold_clr),
    .en_i  (granted),
    .err_o (arb_err)
  );

  always_comb begin
    sel_addr  = (owner_q == REQ_I) ? i_addr    : d_addr;
    sel_data  = (owner_q == REQ_I) ? i_data_in : d_data_in;
    sel_wr    = (owner_q == REQ_I) ? i_wr      : d_wr;
    sel_rd    = (owner_q == REQ_I) ? i_rd      : d_rd;
    proto_err = granted && sel_wr && sel_rd;

    i_grant    = 1'b0;
    d_grant    = 1'b0;
    m_addr     = '0;
    m_data_in  = '0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    i_data_out = '0;
    d_data_out = '0;
    i_busy     = '1;
    d_busy     = '1;
    i_err      = 1'b0;
    d_err      = 1'b0;

    if (granted) begin
      m_addr    = sel_addr;
      m_data_in = sel_data;
      m_wr      = sel_wr & ~sel_rd;
      m_rd      = sel_rd & ~sel_wr;
      if (owner_q == REQ_I) i_grant = 1'b1;
      else                  d_grant = 1'b1;
    end

    if (routed) begin
      if (owner_q == REQ_I) begin
        i_busy     = m_busy;
        i_data_out = m_data_out;
        i_err      = m_err | proto_err;
      end else begin
        d_busy     = m_busy;
        d_data_out = m_data_out;
        d_err      = m_err | proto_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random bursts
// compared every cycle against a burst-level ownership model.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned NB = 4;
  localparam int unsigned MH = 64;

  logic clk = 1'b0;
  logic rst;
  logic i_req, i_wr, i_rd, d_req, d_wr, d_rd, m_err;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_data_in, d_data_in, m_data_out;
  logic [NB-1:0] m_busy;
  logic i_grant, d_grant, i_err, d_err, m_wr, m_rd, arb_err;
  logic [DW-1:0] i_data_out, d_data_out, m_data_in;
  logic [NB-1:0] i_busy, d_busy;
  logic [AW-1:0] m_addr;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  // Model: who owns memory (0 none, 1 I, 2 D), whether that owner has released
  // and we wait for banks to go quiet, who wins the next tie, and hold tracking.
  int unsigned own;
  bit          releasing;
  bit          tie_to_i;
  int unsigned held;
  bit          sticky;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .BANKS(NB),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in), .i_wr(i_wr), .i_rd(i_rd),
    .i_grant(i_grant), .i_data_out(i_data_out), .i_busy(i_busy), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in), .d_wr(d_wr), .d_rd(d_rd),
    .d_grant(d_grant), .d_data_out(d_data_out), .d_busy(d_busy), .d_err(d_err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_err(m_err),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; releasing = 1'b0; tie_to_i = 1'b0; held = 0; sticky = 1'b0;
  endtask

  task automatic check_all(input string ph);
    bit g, both;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    logic ow, orr;
    g   = (own != 0) && !releasing;
    oa  = (own == 1) ? i_addr    : d_addr;
    od  = (own == 1) ? i_data_in : d_data_in;
    ow  = (own == 1) ? i_wr      : d_wr;
    orr = (own == 1) ? i_rd      : d_rd;
    both = ow && orr;
    chk({ph, ".i_grant"},    32'(i_grant),    32'(g && own == 1));
    chk({ph, ".d_grant"},    32'(d_grant),    32'(g && own == 2));
    chk({ph, ".m_addr"},     32'(m_addr),     g ? 32'(oa) : 32'd0);
    chk({ph, ".m_data_in"},  32'(m_data_in),  g ? 32'(od) : 32'd0);
    chk({ph, ".m_wr"},       32'(m_wr),       32'(g && ow && !orr));
    chk({ph, ".m_rd"},       32'(m_rd),       32'(g && orr && !ow));
    chk({ph, ".i_busy"},     32'(i_busy),     (own == 1) ? 32'(m_busy) : 32'hF);
    chk({ph, ".d_busy"},     32'(d_busy),     (own == 2) ? 32'(m_busy) : 32'hF);
    chk({ph, ".i_data_out"}, 32'(i_data_out), (own == 1) ? 32'(m_data_out) : 32'd0);
    chk({ph, ".d_data_out"}, 32'(d_data_out), (own == 2) ? 32'(m_data_out) : 32'd0);
    chk({ph, ".i_err"},      32'(i_err),      32'(own == 1 && (m_err || (g && both))));
    chk({ph, ".d_err"},      32'(d_err),      32'(own == 2 && (m_err || (g && both))));
    chk({ph, ".arb_err"},    32'(arb_err),    32'(sticky));
  endtask

  task automatic model_edge();
    if (own == 0) begin
      if (i_req && d_req) begin
        own = tie_to_i ? 1 : 2;
        tie_to_i = (own == 2);
        held = 0;
      end else if (i_req) begin
        own = 1; held = 0;
      end else if (d_req) begin
        own = 2; held = 0;
      end
    end else if (releasing) begin
      if (m_busy == 0) begin
        own = 0; releasing = 1'b0;
      end
    end else begin
      held++;
      if (held >= MH) sticky = 1'b1;
      if (!((own == 1) ? i_req : d_req)) releasing = 1'b1;
    end
  endtask

  task automatic vec(input string ph);
    #1;
    check_all(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sync_reset();
    @(posedge clk); #1;
    rst = 1'b1; model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rdata;
    rst = 1'b1;
    i_req = 0; i_wr = 0; i_rd = 0; i_addr = '0; i_data_in = '0;
    d_req = 0; d_wr = 0; d_rd = 0; d_addr = '0; d_data_in = '0;
    m_busy = '0; m_err = 0; m_data_out = 16'hBEEF;
    model_reset();
    #1;
    check_all("por");
    sync_reset();

    // Single D request: grant the next cycle and route D to memory.
    d_req = 1; d_rd = 1; d_addr = 16'h1230; d_data_in = 16'h5A5A;
    vec("d_only_req");
    #1;
    chk("tp1.d_grant", 32'(d_grant), 32'd1);
    chk("tp1.m_addr", 32'(m_addr), 32'h1230);
    chk("tp1.m_rd", 32'(m_rd), 32'd1);
    chk("tp1.i_busy", 32'(i_busy), 32'hF);
    chk("tp1.i_data_out", 32'(i_data_out), 32'd0);
    vec("d_only_grant");
    d_req = 0; d_rd = 0;
    repeat (2) vec("d_only_release");

    // Collisions from reset: D first, then I (pointer flipped), then D again.
    sync_reset();
    i_req = 1; d_req = 1; i_rd = 1; i_addr = 16'h0040; d_addr = 16'h0080;
    vec("coll1");
    vec("coll1_d");
    d_req = 0;
    repeat (3) vec("coll1_handover");
    #1;
    chk("coll1.i_grant_n3", 32'(i_grant), 32'd1);
    i_req = 0;
    repeat (3) vec("coll1_i_release");
    i_req = 1; d_req = 1;
    vec("coll2");
    #1;
    chk("coll2.i_wins", 32'(i_grant), 32'd1);
    i_req = 0;
    repeat (4) vec("coll2_handover");
    d_req = 0;
    repeat (3) vec("coll2_release");
    i_req = 1; d_req = 1;
    vec("coll3");
    #1;
    chk("coll3.d_wins", 32'(d_grant), 32'd1);
    chk("coll3.i_loses", 32'(i_grant), 32'd0);

    // D releases with bank 2 still busy: hold I off and keep D's return path.
    d_req = 0; m_busy = 4'b0100;
    vec("drain_enter");
    for (int k = 0; k < 3; k++) begin
      rdata = DW'($urandom);
      m_data_out = rdata;
      #1;
      chk("drain.d_data_out", 32'(d_data_out), 32'(rdata));
      chk("drain.i_grant", 32'(i_grant), 32'd0);
      vec("drain_hold");
    end
    m_busy = '0;
    repeat (2) vec("drain_exit");
    #1;
    chk("drain.i_grant_after", 32'(i_grant), 32'd1);

    // I owns memory: conflicting strobes, then a memory error.
    i_wr = 1; i_rd = 1;
    #1;
    chk("proto.m_wr", 32'(m_wr), 32'd0);
    chk("proto.m_rd", 32'(m_rd), 32'd0);
    chk("proto.i_err", 32'(i_err), 32'd1);
    vec("proto");
    i_wr = 0; m_err = 1;
    #1;
    chk("merr.i_err", 32'(i_err), 32'd1);
    chk("merr.d_err", 32'(d_err), 32'd0);
    vec("merr");
    m_err = 0; i_req = 0; i_rd = 0;
    repeat (3) vec("merr_release");

    // Random bursts from both caches.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) i_req = ~i_req;
      if ($urandom_range(0, 9) == 0) d_req = ~d_req;
      i_wr = ($urandom_range(0, 2) == 0);
      i_rd = ($urandom_range(0, 2) == 0);
      d_wr = ($urandom_range(0, 2) == 0);
      d_rd = ($urandom_range(0, 2) == 0);
      i_addr = AW'($urandom); d_addr = AW'($urandom);
      i_data_in = DW'($urandom); d_data_in = DW'($urandom);
      m_data_out = DW'($urandom);
      m_busy = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
      m_err = ($urandom_range(0, 15) == 0);
      vec("rand");
    end
    i_req = 0; d_req = 0; i_wr = 0; i_rd = 0; d_wr = 0; d_rd = 0;
    m_busy = '0; m_err = 0;

    // Asynchronous reset in the middle of a D grant.
    sync_reset();
    d_req = 1; d_rd = 1; m_busy = 4'b0011;
    repeat (2) vec("pre_async");
    #2;
    rst = 1'b1; model_reset();
    #1;
    chk("async.d_grant", 32'(d_grant), 32'd0);
    chk("async.d_busy", 32'(d_busy), 32'hF);
    check_all("async_rst");
    #1;
    rst = 1'b0; m_busy = '0;

    // Hold ownership past MAX_HOLD: sticky error, grant kept.
    repeat (MH + 6) vec("hold");
    #1;
    chk("hold.arb_err", 32'(arb_err), 32'd1);
    chk("hold.d_grant", 32'(d_grant), 32'd1);
    d_req = 0; d_rd = 0;
    repeat (3) vec("hold_release");
    #1;
    chk("hold.arb_err_sticky", 32'(arb_err), 32'd1);
    sync_reset();
    #1;
    chk("hold.arb_err_cleared", 32'(arb_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
